// File: rtl/lc3_hazard_ctrl.sv
// Hazard controller for the LC-3 five-stage pipeline. It produces the stage
// enables, branch redirect and operand forwarding selects, and sequences the
// data-memory phases with a timeout. It also counts fetch-stall cycles.
module lc3_hazard_ctrl #(
    parameter bit          BYPASS_EN   = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      IR,
    input  logic [15:0]      IR_Exec,
    input  logic             exec_valid,
    input  logic [2:0]       NZP,
    input  logic [2:0]       psr,
    input  logic             complete_data,
    input  logic             complete_instr,
    output logic             enable_updatePC,
    output logic             enable_fetch,
    output logic             enable_decode,
    output logic             enable_execute,
    output logic             enable_writeback,
    output logic             br_taken,
    output logic             bypass_alu_1,
    output logic             bypass_alu_2,
    output logic             bypass_mem_1,
    output logic             bypass_mem_2,
    output logic [2:0]       mem_state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [2:0] {
        MS_READ  = 3'd0,
        MS_IND   = 3'd1,
        MS_WRITE = 3'd2,
        MS_IDLE  = 3'd3,
        MS_ABORT = 3'd4
    } mem_state_e;

    mem_state_e       mem_q, mem_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ind_st_q, ind_st_d;
    logic [4:0]       en_q, en_d;   // {updatePC, fetch, decode, execute, writeback}
    logic             br_q, br_d;
    logic [3:0]       byp_q, byp_d; // {alu_1, alu_2, mem_1, mem_2}
    logic             err_q;
    logic [CNT_W-1:0] stall_q;

    logic [3:0] dec_op, exe_op;
    logic [2:0] src1, src2, dest;
    logic       src1_vld, src2_vld, alu_prod, mem_prod, hit1, hit2;
    logic       flush, interlock;

    logic unused_bits;
    assign unused_bits = ^{IR[4:3], IR_Exec[8:0]};

    // Operand/producer decode of the decode- and execute-stage instructions
    always_comb begin
        dec_op   = IR[15:12];
        exe_op   = IR_Exec[15:12];
        dest     = IR_Exec[11:9];
        src1     = IR[8:6];
        src1_vld = dec_op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP};
        src2     = (dec_op inside {OP_ADD, OP_AND}) ? IR[2:0] : IR[11:9];
        src2_vld = ((dec_op inside {OP_ADD, OP_AND}) && !IR[5]) ||
                   (dec_op inside {OP_ST, OP_STI, OP_STR});
        alu_prod = exe_op inside {OP_ADD, OP_AND, OP_NOT};
        mem_prod = exe_op inside {OP_LD, OP_LDR, OP_LDI, OP_LEA};
        hit1     = src1_vld && (src1 == dest);
        hit2     = src2_vld && (src2 == dest);
        flush    = exec_valid && ((exe_op == OP_JMP) ||
                                  ((exe_op == OP_BR) && (|(NZP & psr))));
        interlock = !BYPASS_EN && exec_valid && (alu_prod || mem_prod) && (hit1 || hit2);
    end

    // Memory phase sequencer next state with per-phase timeout
    always_comb begin
        mem_d    = mem_q;
        timer_d  = timer_q;
        ind_st_d = ind_st_q;
        unique case (mem_q)
            MS_IDLE: begin
                if (exec_valid) begin
                    unique case (exe_op)
                        OP_LD, OP_LDR: mem_d = MS_READ;
                        OP_LDI: begin
                            mem_d    = MS_IND;
                            ind_st_d = 1'b0;
                        end
                        OP_STI: begin
                            mem_d    = MS_IND;
                            ind_st_d = 1'b1;
                        end
                        OP_ST, OP_STR: mem_d = MS_WRITE;
                        default: mem_d = MS_IDLE;
                    endcase
                end
            end
            MS_READ, MS_IND, MS_WRITE: begin
                if (complete_data) begin
                    if (mem_q == MS_IND) begin
                        mem_d = ind_st_q ? MS_WRITE : MS_READ;
                    end else begin
                        mem_d = MS_IDLE;
                    end
                end else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
                    mem_d = MS_ABORT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            MS_ABORT: mem_d = MS_IDLE;
            default:  mem_d = MS_IDLE;
        endcase
        if (mem_d != mem_q) begin
            timer_d = '0;
        end
    end

    // Stage enables by priority: memory stall, flush, interlock, fetch wait
    always_comb begin
        en_d  = 5'b11111;
        br_d  = 1'b0;
        byp_d = '0;
        if (mem_d != MS_IDLE) begin
            en_d = 5'b00000;
        end else if (flush) begin
            en_d = 5'b11001;
            br_d = 1'b1;
        end else if (interlock) begin
            en_d = 5'b00001;
        end else if (!complete_instr) begin
            en_d = 5'b00011;
        end
        if (BYPASS_EN) begin
            byp_d = {hit1 && alu_prod, hit2 && alu_prod, hit1 && mem_prod, hit2 && mem_prod};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= MS_IDLE;
            timer_q  <= '0;
            ind_st_q <= 1'b0;
            en_q     <= '0;
            br_q     <= 1'b0;
            byp_q    <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            timer_q  <= timer_d;
            ind_st_q <= ind_st_d;
            en_q     <= en_d;
            br_q     <= br_d;
            byp_q    <= byp_d;
            err_q    <= (mem_d == MS_ABORT);
            if (!en_q[3] && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign enable_updatePC  = en_q[4];
    assign enable_fetch     = en_q[3];
    assign enable_decode    = en_q[2];
    assign enable_execute   = en_q[1];
    assign enable_writeback = en_q[0];
    assign br_taken         = br_q;
    assign bypass_alu_1     = byp_q[3];
    assign bypass_alu_2     = byp_q[2];
    assign bypass_mem_1     = byp_q[1];
    assign bypass_mem_2     = byp_q[0];
    assign mem_state        = mem_q;
    assign mem_err          = err_q;
    assign stall_cnt        = stall_q;

endmodule

// File: tb/tb_lc3_hazard_ctrl.sv
// Bench for lc3_hazard_ctrl: two instances (forwarding and interlock mode)
// share stimulus; a reference model queues expected outputs per cycle and a
// monitor compares after every rising edge.
module tb_lc3_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IR, IR_Exec;
    logic        exec_valid;
    logic [2:0]  NZP, psr;
    logic        complete_data, complete_instr;

    logic [4:0]  a_en, b_en;
    logic        a_br, b_br, a_err, b_err;
    logic [3:0]  a_byp, b_byp;
    logic [2:0]  a_ms, b_ms;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    lc3_hazard_ctrl #(.BYPASS_EN(1'b1), .MEM_TIMEOUT(TO), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .IR(IR), .IR_Exec(IR_Exec), .exec_valid(exec_valid),
        .NZP(NZP), .psr(psr), .complete_data(complete_data), .complete_instr(complete_instr),
        .enable_updatePC(a_en[4]), .enable_fetch(a_en[3]), .enable_decode(a_en[2]),
        .enable_execute(a_en[1]), .enable_writeback(a_en[0]), .br_taken(a_br),
        .bypass_alu_1(a_byp[3]), .bypass_alu_2(a_byp[2]), .bypass_mem_1(a_byp[1]),
        .bypass_mem_2(a_byp[0]), .mem_state(a_ms), .mem_err(a_err), .stall_cnt(a_cnt)
    );

    lc3_hazard_ctrl #(.BYPASS_EN(1'b0), .MEM_TIMEOUT(TO), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .IR(IR), .IR_Exec(IR_Exec), .exec_valid(exec_valid),
        .NZP(NZP), .psr(psr), .complete_data(complete_data), .complete_instr(complete_instr),
        .enable_updatePC(b_en[4]), .enable_fetch(b_en[3]), .enable_decode(b_en[2]),
        .enable_execute(b_en[1]), .enable_writeback(b_en[0]), .br_taken(b_br),
        .bypass_alu_1(b_byp[3]), .bypass_alu_2(b_byp[2]), .bypass_mem_1(b_byp[1]),
        .bypass_mem_2(b_byp[0]), .mem_state(b_ms), .mem_err(b_err), .stall_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [29:0] q0[$];
    logic [29:0] q1[$];

    // Model state per instance: current phase (-1 idle, 0 read, 1 ind, 2 write,
    // 4 abort), the phase that follows on completion, cycles spent in phase,
    // last enable_fetch and stall counter.
    int cur[2]      = '{-1, -1};
    int after_ph[2] = '{-1, -1};
    int wt[2]       = '{0, 0};
    int enf[2]      = '{0, 0};
    int cnt[2]      = '{0, 0};
    int byp_en[2]   = '{1, 0};
    int cmax[2]     = '{65535, 15};

    function automatic logic [15:0] mk(input logic [3:0] op, input int a, input int b,
                                       input bit imm, input int c);
        return {op, 3'(a), 3'(b), imm, 2'b00, 3'(c)};
    endfunction

    task automatic model_step(input int i, output logic [29:0] e);
        logic [3:0] op_d, op_x;
        logic [4:0] en;
        logic       br, s1v, s2v, alu, memp, h1, h2, taken;
        logic [3:0] bp;
        int         s1, s2, dst, ms;
        if (rst) begin
            cur[i] = -1; after_ph[i] = -1; wt[i] = 0; cnt[i] = 0; enf[i] = 0;
            e = {5'b0, 1'b0, 4'b0, 3'd3, 1'b0, 16'd0};
            return;
        end
        if (enf[i] == 0 && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
        op_d = IR[15:12];
        op_x = IR_Exec[15:12];
        if (cur[i] == 4) begin
            cur[i] = -1;
        end else if (cur[i] == -1) begin
            if (exec_valid) begin
                wt[i] = 0;
                case (op_x)
                    4'b0010, 4'b0110: begin cur[i] = 0; after_ph[i] = -1; end
                    4'b1010:          begin cur[i] = 1; after_ph[i] = 0;  end
                    4'b1011:          begin cur[i] = 1; after_ph[i] = 2;  end
                    4'b0011, 4'b0111: begin cur[i] = 2; after_ph[i] = -1; end
                    default: ;
                endcase
            end
        end else if (complete_data) begin
            cur[i] = after_ph[i]; after_ph[i] = -1; wt[i] = 0;
        end else if (wt[i] == int'(TO) - 1) begin
            cur[i] = 4; wt[i] = 0;
        end else begin
            wt[i] = wt[i] + 1;
        end
        s1v  = op_d inside {4'b0001, 4'b0101, 4'b1001, 4'b0110, 4'b0111, 4'b1100};
        s2v  = ((op_d inside {4'b0001, 4'b0101}) && !IR[5]) || (op_d inside {4'b0011, 4'b1011, 4'b0111});
        s1   = int'(IR[8:6]);
        s2   = (op_d inside {4'b0001, 4'b0101}) ? int'(IR[2:0]) : int'(IR[11:9]);
        dst  = int'(IR_Exec[11:9]);
        alu  = op_x inside {4'b0001, 4'b0101, 4'b1001};
        memp = op_x inside {4'b0010, 4'b0110, 4'b1010, 4'b1110};
        h1   = s1v && (s1 == dst);
        h2   = s2v && (s2 == dst);
        taken = exec_valid && (op_x == 4'b1100 || (op_x == 4'b0000 && (NZP & psr) != 3'b000));
        br = 1'b0;
        if (cur[i] != -1)                                           en = 5'b00000;
        else if (taken) begin                                       en = 5'b11001; br = 1'b1; end
        else if (byp_en[i] == 0 && exec_valid && (alu || memp) && (h1 || h2)) en = 5'b00001;
        else if (!complete_instr)                                   en = 5'b00011;
        else                                                        en = 5'b11111;
        bp = (byp_en[i] != 0) ? {h1 && alu, h2 && alu, h1 && memp, h2 && memp} : 4'b0000;
        enf[i] = int'(en[3]);
        ms = (cur[i] == -1) ? 3 : cur[i];
        e = {en, br, bp, 3'(ms), (cur[i] == 4), 16'(cnt[i])};
    endtask

    // Model both instances for the current inputs, then advance one cycle
    task automatic step();
        logic [29:0] e;
        model_step(0, e); q0.push_back(e);
        model_step(1, e); q1.push_back(e);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [29:0] act, input logic [29:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual={en,br,byp,ms,err,cnt}=%h required=%h", nm, $time, act, exp);
    endtask

    // Monitor: compare every registered output set just after the edge
    always @(posedge clk) begin
        logic [29:0] e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("fwd_mode", {a_en, a_br, a_byp, a_ms, a_err, a_cnt}, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("interlock_mode", {b_en, b_br, b_byp, b_ms, b_err, 12'd0, b_cnt}, e);
        end
    end

    task automatic idle_inputs();
        exec_valid = 1'b0; complete_data = 1'b0; complete_instr = 1'b1;
        NZP = 3'b000; psr = 3'b010;
    endtask

    initial begin
        rst = 1'b1; IR = 16'h0000; IR_Exec = 16'h0000;
        idle_inputs();
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        step();

        // ADD R1,R2,R3 executing, ADD R4,R1,R1 decoding
        IR_Exec = mk(4'b0001, 1, 2, 1'b0, 3); IR = mk(4'b0001, 4, 1, 1'b0, 1);
        exec_valid = 1'b1; step();
        exec_valid = 1'b0; IR = mk(4'b0001, 5, 6, 1'b0, 7); step();
        step();

        // LDI: indirect phase completes on its third cycle, read immediately
        IR_Exec = mk(4'b1010, 2, 0, 1'b0, 0); exec_valid = 1'b1; step();
        exec_valid = 1'b0; step(); step();
        complete_data = 1'b1; step(); step();
        complete_data = 1'b0; step(); step();

        // STR with no completion: timeout abort
        IR_Exec = mk(4'b0111, 1, 2, 1'b0, 0); exec_valid = 1'b1; step();
        exec_valid = 1'b0; repeat (7) step();

        // BR taken, then not taken, then JMP
        IR_Exec = mk(4'b0000, 2, 0, 1'b0, 0); NZP = 3'b010; psr = 3'b010;
        exec_valid = 1'b1; step();
        exec_valid = 1'b0; step();
        psr = 3'b100; exec_valid = 1'b1; step();
        exec_valid = 1'b0; step();
        IR_Exec = mk(4'b1100, 0, 3, 1'b0, 0); exec_valid = 1'b1; step();
        idle_inputs(); step();

        // STI with zero wait, then reset during a write
        IR_Exec = mk(4'b1011, 1, 0, 1'b0, 0); exec_valid = 1'b1; step();
        exec_valid = 1'b0; complete_data = 1'b1; step(); step();
        complete_data = 1'b0; step();
        IR_Exec = mk(4'b0011, 1, 0, 1'b0, 0); exec_valid = 1'b1; step();
        exec_valid = 1'b0; step();
        rst = 1'b1; step();
        rst = 1'b0; step(); step();

        // Instruction memory not ready
        complete_instr = 1'b0; repeat (3) step();
        complete_instr = 1'b1; step();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] opx, opd;
            opx = 4'($urandom_range(0, 15));
            opd = 4'($urandom_range(0, 15));
            IR_Exec = mk(opx, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
            IR      = mk(opd, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
            exec_valid     = (cur[0] == -1) && ($urandom_range(0, 2) == 0);
            complete_data  = ($urandom_range(0, 99) < 35);
            complete_instr = ($urandom_range(0, 99) < 85);
            NZP = 3'($urandom); psr = 3'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; idle_inputs(); step(); step();

        for (int w = 0; w < 10 && (q0.size() > 0 || q1.size() > 0); w++) @(negedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d required=0", q0.size() + q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
